bitrev_reorder_ctrl: RTL
========================

BITREV_REORDER_CTRL -- requirements
Module: bitrev_reorder_ctrl

Interface
REQ-001 Parameter W, default 4: address bits; frame length N = 2^W samples.
REQ-002 Parameter DW, default 16: sample data width in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  an input sample is present.
REQ-007 in_ready  output  1  the block can accept an input sample.
REQ-008 in_data  input  DW  input sample, natural order.
REQ-009 out_valid  output  1  an output sample is present.
REQ-010 out_ready  input  1  the downstream block accepts the output sample.
REQ-011 out_data  output  DW  output sample, bit-reversed order.
REQ-012 out_last  output  1  final sample of a frame; present only with BITREV_LAST_EN.

Function
REQ-013 SHALL hold two banks (bank 0, bank 1) of N x DW storage as a ping-pong buffer.
REQ-014 Each bank SHALL have a state flag: EMPTY or FULL.
REQ-015 Write side: registers wbank (1 bit) and wcnt (W bits); in_ready = (state[wbank] == EMPTY).
REQ-016 On an input handshake (in_valid & in_ready), the block SHALL write in_data to bank[wbank][wcnt] and increment wcnt modulo N.
REQ-017 On a handshake with wcnt == N-1, the block SHALL set state[wbank] = FULL, toggle wbank, and wrap wcnt to 0.
REQ-018 Read side: registers rbank (1 bit) and rcnt (W bits); out_valid = (state[rbank] == FULL).
REQ-019 out_data SHALL equal bank[rbank][rev(rcnt)], where rev(rcnt)[i] = rcnt[W-1-i] for i = 0..W-1; the value is combinational from the registered state.
REQ-020 On an output handshake (out_valid & out_ready), rcnt SHALL increment modulo N.
REQ-021 On an output handshake with rcnt == N-1, the block SHALL set state[rbank] = EMPTY, toggle rbank, and wrap rcnt to 0.
REQ-022 Latency: out_valid SHALL first rise in the cycle after the handshake of sample N-1 of a frame.
REQ-023 When out_valid is high and out_ready is low, out_data and out_valid SHALL hold stable.
REQ-024 Filling bank X and draining bank Y in the same cycle SHALL both proceed: full-rate streaming, no bubbles.
REQ-025 When both banks are FULL, in_ready SHALL be 0 until the drain of rbank completes.
REQ-026 In the cycle the drain of bank X completes, in_ready SHALL still read the old FULL state; it rises on the next cycle.
REQ-027 When both banks are EMPTY, out_valid SHALL be 0 and out_ready SHALL be ignored.
REQ-028 The set (write side) and clear (read side) of a state flag SHALL never target the same bank in one cycle; the bench SHALL assert this.
REQ-029 in_data SHALL be ignored and storage left unchanged when no input handshake occurs.

Reset
REQ-030 On rst, the block SHALL set: wbank = 0, wcnt = 0, rbank = 0, rcnt = 0, both states EMPTY.
REQ-031 Output values during and after reset: in_ready = 1, out_valid = 0, out_last = 0; out_data is don't-care.
REQ-032 Storage contents SHALL not be reset.
REQ-033 Reset asserted mid-frame SHALL discard all partial and full frames; the next input after reset is sample 0 of a new frame.

Configuration
REQ-034 Macro BITREV_LAST_EN defined: the out_last port exists, with out_last = out_valid & (rcnt == N-1).
REQ-035 Macro BITREV_LAST_EN undefined: the out_last port and its logic are absent; all other behaviour is identical.

Verification
REQ-036 W=4; stream inputs 0..15 with out_ready=1 -> outputs 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_valid rises the cycle after input 15 is accepted.
REQ-037 Stream 3 frames back-to-back with in_valid=1 and out_ready=1 -> in_ready stays 1 throughout; each frame is output in bit-reversed order with no gap between frames.
REQ-038 out_ready=0 and 2 full frames written -> in_ready=0 on the cycle after the 32nd accept; raise out_ready -> in_ready returns to 1 one cycle after the 16th output.
REQ-039 Random out_ready (50%) over 10 frames -> out_data is stable while out_valid & !out_ready, and the sequence matches the reference model.
REQ-040 Assert rst after 7 inputs -> out_valid=0 and in_ready=1; the next 16 inputs 100..115 output as 100,108,104,...,115.
REQ-041 With BITREV_LAST_EN: out_last=1 only on the outputs of values 15, 31, 47 in the streaming test; without the macro, the build has no out_last port.

Source files
------------

// File: rtl/bitrev_reorder_ctrl.sv
// Ping-pong frame buffer: accepts N=2^W samples in natural order and
// emits them in bit-reversed order. Optional out_last via BITREV_LAST_EN.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data write
// stream; out_valid/out_ready/out_data read stream; out_last (macro only).
module bitrev_reorder_ctrl #(
  parameter int W  = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
`ifdef BITREV_LAST_EN
  ,
  output logic          out_last
`endif
);

  localparam int N = 1 << W;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_st_t;

  logic [DW-1:0] mem [2][N];
  bank_st_t      st [2];

  logic          wbank;
  logic [W-1:0]  wcnt;
  logic          rbank;
  logic [W-1:0]  rcnt;
  logic [W-1:0]  raddr;

  logic          in_hs;
  logic          out_hs;
  logic          wr_done;
  logic          rd_done;

  assign in_ready  = (st[wbank] == EMPTY);
  assign out_valid = (st[rbank] == FULL);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign wr_done   = in_hs && (wcnt == '1);
  assign rd_done   = out_hs && (rcnt == '1);

  always_comb begin
    raddr = '0;
    for (int i = 0; i < W; i++) begin
      raddr[i] = rcnt[W-1-i];
    end
  end

  assign out_data = mem[rbank][raddr];

`ifdef BITREV_LAST_EN
  assign out_last = out_valid && (rcnt == '1);
`endif

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem[wbank][wcnt] <= in_data;
    end
  end

  // A bank being written is EMPTY and one being read is FULL, so the
  // set and clear below can never hit the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank <= 1'b0;
      wcnt  <= '0;
      rbank <= 1'b0;
      rcnt  <= '0;
      st[0] <= EMPTY;
      st[1] <= EMPTY;
    end else begin
      if (in_hs) begin
        wcnt <= wcnt + 1'b1;
      end
      if (wr_done) begin
        wbank <= ~wbank;
      end
      if (out_hs) begin
        rcnt <= rcnt + 1'b1;
      end
      if (rd_done) begin
        rbank <= ~rbank;
      end
      for (int b = 0; b < 2; b++) begin
        if (wr_done && (wbank == 1'(b))) begin
          st[b] <= FULL;
        end else if (rd_done && (rbank == 1'(b))) begin
          st[b] <= EMPTY;
        end
      end
    end
  end

endmodule
